// File: rtl/conv_window_controller_if.sv
// Pixel handshake and window-result bus between the pixel source, the
// convolution layer and the window controller.
interface conv_window_controller_if #(
    parameter int CW = 3,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    // Pixel source side: offers pixels, observes acceptance and window results.
    modport master (
        output in_valid,
        input  in_ready,
        input  shift_en,
        input  out_valid,
        input  out_row,
        input  out_col
    );

    // Controller side.
    modport slave (
        input  in_valid,
        output in_ready,
        output shift_en,
        output out_valid,
        output out_row,
        output out_col
    );
endinterface

// File: rtl/conv_window_controller.sv
// Frame sequencer for the convolution_2D layer: accepts a pixel stream,
// advances the layer shift register, tags legal KxK windows and delays those
// tags through a model of the multiply-adder tree latency so that out_valid,
// out_row and out_col line up with the layer's pixel_out.
module conv_window_controller #(
    parameter int IMG_WIDTH    = 6,
    parameter int IMG_HEIGHT   = 6,
    parameter int KERNEL_SIZE  = 4,
    parameter int PIPE_LATENCY = 5,
    parameter int CW           = $clog2(IMG_WIDTH),
    parameter int RW           = $clog2(IMG_HEIGHT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    conv_window_controller_if.slave      bus,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] MIN_COL    = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] MIN_ROW    = RW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_d;

    logic          in_ready;
    logic          accept;

    // Window tag for the pixel being accepted this cycle (pre-increment position).
    logic          tag_vld;
    logic [RW-1:0] tag_row;
    logic [CW-1:0] tag_col;

    // Latency model of the multiply-adder tree, one entry per pipeline stage.
    logic          vld_p [PIPE_LATENCY];
    logic [RW-1:0] row_p [PIPE_LATENCY];
    logic [CW-1:0] col_p [PIPE_LATENCY];

    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // abort wins over an accept in the same cycle, so in_ready drops with it.
    assign in_ready = (state_q == STREAM) && !abort;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.shift_en  = accept;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign busy          = (state_q != IDLE);

    // A window is legal once K rows and K columns have entered the shift register.
    assign tag_vld = accept && (row_q >= MIN_ROW) && (col_q >= MIN_COL);
    assign tag_row = row_q - MIN_ROW;
    assign tag_col = col_q - MIN_COL;

    // State, position and drain counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            frame_done <= done_d;
        end
    end

    // Next-state logic: raster position tracking and drain timing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // The frame_done cycle is still part of the finishing frame.
                    if (start && !frame_done) begin
                        state_d = STREAM;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                row_d   = '0;
                                drain_d = '0;
                                state_d = DRAIN;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last tag leaves the latency model on this edge.
                    if (drain_q == LAST_DRAIN) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Tag delay line: shifts every clock, stalls become bubbles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                row_p[i] <= '0;
                col_p[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else if (abort) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                row_p[i] <= '0;
                col_p[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            vld_p[0] <= tag_vld;
            row_p[0] <= tag_row;
            col_p[0] <= tag_col;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                row_p[i] <= row_p[i-1];
                col_p[i] <= col_p[i-1];
            end
            out_valid_q <= vld_p[PIPE_LATENCY-1];
            out_row_q   <= row_p[PIPE_LATENCY-1];
            out_col_q   <= col_p[PIPE_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_conv_window_controller.sv
// Scoreboard bench for conv_window_controller: expected windows and
// frame_done edges are computed from the stimulus schedule and matched
// against the DUT outputs edge by edge.
module tb_conv_window_controller;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int K  = 4;
    localparam int P  = 5;
    localparam int CW = 3;
    localparam int RW = 3;

    typedef struct {
        int e;
        int r;
        int c;
    } exp_t;

    logic clock;
    logic reset;
    logic start;
    logic abort;
    logic busy;
    logic frame_done;

    conv_window_controller_if #(.CW(CW), .RW(RW)) bus ();

    conv_window_controller #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .PIPE_LATENCY(P)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done)
    );

    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    int   pulses = 0;
    int   dones = 0;
    exp_t exp_q[$];
    int   done_q[$];
    int   start_sched[$];
    int   abort_edge = -1;
    int   stall_lo = -1;
    int   stall_hi = -2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) ecnt <= ecnt + 1;

    // Scoreboard monitor, sampling 1 time unit after each rising edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (bus.out_valid === 1'b1) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL window_unexpected edge=%0d got row=%0d col=%0d expected none",
                         ecnt, bus.out_row, bus.out_col);
            end else begin
                e = exp_q.pop_front();
                if (ecnt !== e.e || bus.out_row !== RW'(e.r) || bus.out_col !== CW'(e.c)) begin
                    bad++;
                    $display("FAIL window got edge=%0d row=%0d col=%0d expected edge=%0d row=%0d col=%0d",
                             ecnt, bus.out_row, bus.out_col, e.e, e.r, e.c);
                end
            end
        end
        if (frame_done === 1'b1) begin
            dones++;
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL frame_done_unexpected edge=%0d expected none", ecnt);
            end else if (ecnt !== done_q[0]) begin
                bad++;
                $display("FAIL frame_done_edge got=%0d expected=%0d", ecnt, done_q[0]);
                void'(done_q.pop_front());
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    // Reference model: pixel n of a frame started at edge s is accepted at
    // edge s+1+n, plus any stall cycles inserted before pixel stall_px.
    task automatic push_frame(input int s, input int stall_px, input int stall_len,
                              input int cut, input bit with_done);
        int acc;
        exp_t e;
        for (int n = 0; n < W * H; n++) begin
            acc = s + 1 + n + ((n >= stall_px) ? stall_len : 0);
            if ((n / W) >= K - 1 && (n % W) >= K - 1 && acc + P <= cut) begin
                e.e = acc + P;
                e.r = n / W - (K - 1);
                e.c = n % W - (K - 1);
                exp_q.push_back(e);
            end
            if (n == W * H - 1 && with_done) done_q.push_back(acc + P);
        end
    endtask

    // Drive the scheduled start/abort/stall pattern until edge end_e.
    task automatic run_until(input int end_e);
        int nxt;
        bit st;
        while (ecnt < end_e) begin
            nxt = ecnt + 1;
            st = 1'b0;
            foreach (start_sched[i]) if (start_sched[i] == nxt) st = 1'b1;
            start = st;
            abort = (nxt == abort_edge);
            bus.in_valid = !(nxt >= stall_lo && nxt <= stall_hi);
            @(posedge clock);
            #2;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic clear_sched();
        start_sched.delete();
        abort_edge = -1;
        stall_lo = -1;
        stall_hi = -2;
        pulses = 0;
        dones = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b expected=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b expected=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b expected=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b expected=0", frame_done); end
        total++; if (bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin bad++; $display("FAIL rst_coords got=%0d,%0d expected=0,0", bus.out_row, bus.out_col); end
        total++; if (bus.shift_en !== 1'b0) begin bad++; $display("FAIL rst_shift_en got=%b expected=0", bus.shift_en); end
        repeat (3) @(posedge clock);
        #2;
        total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_held busy=%b in_ready=%b expected=0,0", busy, bus.in_ready); end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b expected=0", busy); end
    endtask

    task automatic test_single_frame();
        int s;
        clear_sched();
        s = ecnt + 2;
        start_sched.push_back(s);
        push_frame(s, 1000, 0, 1 << 30, 1'b1);
        run_until(s);
        total++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_started busy=%b in_ready=%b expected=1,1", busy, bus.in_ready); end
        run_until(s + 1);
        total++; if (bus.shift_en !== 1'b1) begin bad++; $display("FAIL single_accept got=%b expected=1", bus.shift_en); end
        run_until(s + 41);
        total++; if (busy !== 1'b0 || frame_done !== 1'b1) begin bad++; $display("FAIL single_end busy=%b frame_done=%b expected=0,1", busy, frame_done); end
        run_until(s + 44);
        total++; if (pulses !== 9 || dones !== 1) begin bad++; $display("FAIL single_counts pulses=%0d dones=%0d expected=9,1", pulses, dones); end
        total++; if (exp_q.size() !== 0 || done_q.size() !== 0) begin bad++; $display("FAIL single_missing windows=%0d dones=%0d expected=0,0", exp_q.size(), done_q.size()); end
    endtask

    task automatic test_stall();
        int s;
        clear_sched();
        s = ecnt + 2;
        start_sched.push_back(s);
        stall_lo = s + 11;
        stall_hi = s + 13;
        push_frame(s, 10, 3, 1 << 30, 1'b1);
        run_until(s + 12);
        total++; if (bus.shift_en !== 1'b0) begin bad++; $display("FAIL stall_shift_en got=%b expected=0", bus.shift_en); end
        run_until(s + 48);
        total++; if (pulses !== 9 || dones !== 1 || exp_q.size() !== 0 || done_q.size() !== 0) begin
            bad++; $display("FAIL stall_counts pulses=%0d dones=%0d left=%0d expected=9,1,0", pulses, dones, exp_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        int s;
        clear_sched();
        s = ecnt + 2;
        start_sched.push_back(s);
        start_sched.push_back(s + 15);
        push_frame(s, 1000, 0, 1 << 30, 1'b1);
        run_until(s + 45);
        total++; if (pulses !== 9 || dones !== 1 || exp_q.size() !== 0 || done_q.size() !== 0) begin
            bad++; $display("FAIL busy_start_counts pulses=%0d dones=%0d left=%0d expected=9,1,0", pulses, dones, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int s;
        int s2;
        clear_sched();
        s = ecnt + 2;
        start_sched.push_back(s);
        abort_edge = s + 28;
        push_frame(s, 1000, 0, s + 27, 1'b0);
        run_until(s + 29);
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL abort_state out_valid=%b busy=%b in_ready=%b expected=0,0,0", bus.out_valid, busy, bus.in_ready);
        end
        run_until(s + 45);
        total++; if (pulses !== 1 || dones !== 0 || exp_q.size() !== 0) begin
            bad++; $display("FAIL abort_counts pulses=%0d dones=%0d left=%0d expected=1,0,0", pulses, dones, exp_q.size());
        end
        clear_sched();
        s2 = ecnt + 2;
        start_sched.push_back(s2);
        push_frame(s2, 1000, 0, 1 << 30, 1'b1);
        run_until(s2 + 45);
        total++; if (pulses !== 9 || dones !== 1 || exp_q.size() !== 0 || done_q.size() !== 0) begin
            bad++; $display("FAIL abort_restart pulses=%0d dones=%0d left=%0d expected=9,1,0", pulses, dones, exp_q.size());
        end
    endtask

    task automatic test_reset_in_drain();
        int s;
        int s2;
        clear_sched();
        s = ecnt + 2;
        start_sched.push_back(s);
        push_frame(s, 1000, 0, s + 38, 1'b0);
        run_until(s + 38);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b expected=1", busy); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || frame_done !== 1'b0 ||
                     bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
            bad++; $display("FAIL async_reset busy=%b in_ready=%b out_valid=%b frame_done=%b row=%0d col=%0d expected all 0",
                            busy, bus.in_ready, bus.out_valid, frame_done, bus.out_row, bus.out_col);
        end
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        total++; if (pulses !== 6 || dones !== 0 || exp_q.size() !== 0) begin
            bad++; $display("FAIL drain_counts pulses=%0d dones=%0d left=%0d expected=6,0,0", pulses, dones, exp_q.size());
        end
        clear_sched();
        s2 = ecnt + 2;
        start_sched.push_back(s2);
        push_frame(s2, 1000, 0, 1 << 30, 1'b1);
        run_until(s2 + 45);
        total++; if (pulses !== 9 || dones !== 1 || exp_q.size() !== 0 || done_q.size() !== 0) begin
            bad++; $display("FAIL reset_restart pulses=%0d dones=%0d left=%0d expected=9,1,0", pulses, dones, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        clear_sched();
        s1 = ecnt + 2;
        s2 = s1 + 43;
        // start is also held during the frame_done cycle, where it must be ignored
        start_sched.push_back(s1);
        start_sched.push_back(s1 + 42);
        start_sched.push_back(s2);
        push_frame(s1, 1000, 0, 1 << 30, 1'b1);
        push_frame(s2, 1000, 0, 1 << 30, 1'b1);
        run_until(s1 + 42);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_cycle_start busy=%b expected=0", busy); end
        run_until(s2 + 45);
        total++; if (pulses !== 18 || dones !== 2 || exp_q.size() !== 0 || done_q.size() !== 0) begin
            bad++; $display("FAIL b2b_counts pulses=%0d dones=%0d left=%0d expected=18,2,0", pulses, dones, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_start_while_busy();
        test_abort();
        test_reset_in_drain();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_controller.md
Name: conv_window_controller

Overview:
Sequences one image frame through the convolution_2D layer.
- Accepts a pixel stream with a valid/ready handshake.
- Drives the layer shift-register advance (shift_en).
- Tracks row/column position and decides which shift positions form a legal KxK window, i.e. windows that do not straddle a row edge.
- Delays that decision through a model of the multiply-adder tree latency, so out_valid and the window coordinates line up with pixel_out.
- Drains the pipeline and signals frame completion.

Parameters:
IMG_WIDTH, 6, pixels per image row (equals P_SR_DEPTH+RAM_SR_DEPTH of the layer)
IMG_HEIGHT, 6, rows per frame
KERNEL_SIZE, 4, window edge K (equals P_SR_DEPTH and NUM_SR_ROWS of the layer)
PIPE_LATENCY, 5, clock edges from a shift_en edge to the corresponding pixel_out being valid; must be >= 1
CW, $clog2(IMG_WIDTH), column counter width
RW, $clog2(IMG_HEIGHT), row counter width

Ports:
clock      input   1   rising-edge clock
reset      input   1   asynchronous, active-low reset
start      input   1   begin a frame; sampled only in IDLE
abort      input   1   synchronous cancel of the current frame
in_valid   input   1   upstream pixel present
in_ready   output  1   controller can accept a pixel
shift_en   output  1   advance the layer shift register and pixel source; equals in_valid & in_ready (combinational)
out_valid  output  1   pixel_out of the layer holds a legal window result this cycle
out_row    output  RW  window row index, 0..IMG_HEIGHT-K, valid with out_valid
out_col    output  CW  window column index, 0..IMG_WIDTH-K, valid with out_valid
busy       output  1   state is not IDLE
frame_done output  1   one-cycle pulse, frame finished

Behaviour:
Reset (reset=0):
- state=IDLE; row/col counters=0; delay line cleared.
- in_ready, out_valid, busy, frame_done = 0; out_row, out_col = 0.

States: IDLE, STREAM, DRAIN.
- IDLE: in_ready=0.
  - start=1 -> STREAM; row and col are cleared to 0.
- STREAM: in_ready=1.
  - On each accept (shift_en=1): col increments; at col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - The accept of pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) -> DRAIN.
- DRAIN: in_ready=0; a drain counter counts PIPE_LATENCY edges.
  - On the final edge: frame_done=1 for exactly one cycle, state -> IDLE, busy -> 0 on the same edge.

Window legality (evaluated on the accepting edge, using pre-increment row/col):
- legal = (row >= K-1) && (col >= K-1).
- The tag pushed is {legal, row-(K-1), col-(K-1)}.

Delay line:
- PIPE_LATENCY stages, shifted every clock regardless of stall.
- A bubble (legal=0) is inserted on non-accept cycles.
- out_valid/out_row/out_col are the registered last stage. A legal accept on edge t gives out_valid=1 in the cycle following edge t+PIPE_LATENCY-1, i.e. it is asserted from edge t+PIPE_LATENCY.

Stalls:
- in_valid=0 in STREAM holds the counters and pushes a bubble.
- No window is ever reported twice or skipped.

Frame-level rules:
- Total out_valid pulses per frame = (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1).
- The final out_valid coincides with frame_done.

abort=1 (any state):
- Next edge: state=IDLE, delay line cleared, out_valid=0.
- frame_done is not pulsed.
- abort has priority over start and accept.

Other boundary rules:
- start while busy is ignored.
- start in the cycle frame_done is high is ignored; start must be presented in IDLE.
- Reset mid-frame restores every reset value immediately and asynchronously.

Test Plan:
1. Defaults, reset release, start at edge 0, in_valid=1 continuously:
   - Pixel 0 is accepted at edge 1; pixel 21 at edge 22.
   - out_valid at edges 27, 28, 29 with (row,col) = (0,0), (0,1), (0,2).
   - Low for 3 cycles, then (1,0) at edge 33.
   - Exactly 9 pulses; the last is (2,2) at edge 41, together with frame_done=1.
   - busy=0 after edge 41.
2. Same as 1, with in_valid=0 for 3 cycles before pixel 10:
   - Every out_valid shifts 3 edges later (first at edge 30).
   - 9 pulses total, with no duplicate coordinates.
3. start pulsed at edge 15 of an active frame:
   - No effect; counts and timing are identical to scenario 1.
4. abort at edge 28:
   - At edge 29: out_valid=0, busy=0, no frame_done, in_ready=0.
   - A new start then yields a full 9-window frame, timed as in scenario 1 relative to that start.
5. reset driven low mid-DRAIN:
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release and start, a correct frame follows.
6. Back-to-back frames, start at the cycle after frame_done:
   - Second frame is timed exactly like scenario 1 relative to its start.
   - 18 out_valid pulses in total.
